pdp8_tt_uart: RTL and testbench
===============================

# pdp8_tt_uart

Serial line engine for the PDP-8 console: the responder side of the console controller's `tx_req`/`tx_ack` and `rx_req`/`rx_ack` handshakes. It transmits 8N1 characters (LSB first) on `tx_out` and receives 8N1 characters on `rx_in`. It buffers one received character until the console controller fetches it. It sits between the console controller and the pads and is timed by baud enables from the baud rate generator.

## Interface
- `OVERSAMPLE`, default 16: `rx_clk` strobes per bit time. Must be a power of two, 8 or more.
- `clk` in 1: system clock, the only clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `tx_clk` in 1: one-`clk`-wide enable, once per bit time.
- `rx_clk` in 1: one-`clk`-wide enable, `OVERSAMPLE` times per bit time.
- `tx_req` in 1: transmit request. Level; held by the controller until `tx_ack`.
- `tx_data` in 8: character to send. Valid while `tx_req` is high.
- `tx_ack` out 1: transmit request accepted.
- `tx_empty` out 1: transmitter idle.
- `tx_out` out 1: serial output. Idle is 1.
- `rx_in` in 1: serial input. Asynchronous.
- `rx_req` in 1: read request. Level.
- `rx_ack` out 1: read accepted; `rx_data` is valid.
- `rx_data` out 8: last character handed over. Held until the next acceptance.
- `rx_empty` out 1: receive holding register empty.
- `rx_overrun` out 1: sticky; a character was lost.
- `rx_frame_err` out 1: one-cycle pulse; a stop bit was sampled as 0.

## Operation
- **Reset values (`reset_n`=0 at an edge):** `tx_out`=1, `tx_empty`=1, `tx_ack`=0, `rx_ack`=0, `rx_empty`=1, `rx_data`=0, `rx_overrun`=0, `rx_frame_err`=0. Both state machines go to IDLE.
- **Reset mid-frame:** the partial frame is abandoned with no error flag.
- **TX capture:**
  - Condition: IDLE, `tx_ack`=0 and `tx_req`=1.
  - Action: shift register loaded with `tx_data`; `tx_ack`=1 and `tx_empty`=0 from the same edge.
  - `tx_ack` clears on the first edge at which `tx_req`=0 is sampled.
  - A `tx_req` that is still high after its capture is not recaptured.
- **TX states:**
  - WAIT_BIT → START on the next `tx_clk`; `tx_out`=0.
  - START → DATA on `tx_clk`; bit0 is driven.
  - DATA advances one bit per `tx_clk` through bit7, using a 3-bit counter.
  - bit7 → STOP on `tx_clk`; `tx_out`=1.
  - STOP → IDLE on `tx_clk`; `tx_empty`=1.
  - `tx_empty` stays 0 continuously from capture to the end of the stop bit, even if `tx_ack` has already dropped.
- **RX input conditioning:** `rx_in` passes through a 2-flop synchronizer. All sampling happens only on `rx_clk` strobes.
- **RX states:**
  - IDLE: synchronized input = 0 at a strobe → START; strobe counter = 0.
  - START: at strobe count `OVERSAMPLE`/2, if the input is 1 (false start) → IDLE with no flags. Otherwise → DATA and the counter resets.
  - DATA: a bit is sampled every `OVERSAMPLE` strobes and shifted in LSB first, 8 bits.
  - STOP, sampled `OVERSAMPLE` strobes after bit7:
    - Stop = 1: holding register ← shift register, `rx_empty`=0, → IDLE.
    - Stop = 0: `rx_frame_err` pulses, the character is discarded, → BREAK.
  - BREAK → IDLE on the first strobe that samples input = 1.
- **Overrun:** a character completes while `rx_empty`=0 and no acceptance happens on that edge. The holding register is overwritten and `rx_overrun`=1.
- **RX acceptance:**
  - Condition: `rx_req`=1, `rx_empty`=0 and `rx_ack`=0.
  - Action: `rx_data` ← holding register, `rx_ack`=1, `rx_empty`=1 and `rx_overrun`=0, all on the same edge.
  - `rx_ack` clears on the first edge at which `rx_req`=0 is sampled.
  - `rx_req` while `rx_empty`=1 is ignored.
- **Simultaneous acceptance and character completion:** `rx_data` gets the old holding value. The new character loads the holding register, `rx_empty` stays 0, and there is no overrun.

## Timing
- **TX capture latency:** `tx_ack` and `tx_empty` change at the edge after `tx_req` is first sampled high.
- **TX frame:** the start bit begins 1 to T_bit after capture (first `tx_clk`, aligned to the bit grid). The frame lasts exactly 10 `tx_clk` periods, and each bit lasts exactly one.
- **RX input latency:** 2 `clk` cycles of synchronizer delay plus up to one `rx_clk` period for start detection.
- **RX completion:** `rx_empty` falls at the stop-sample strobe edge, about 9.5 bit times after the falling edge of the start bit.
- **Ack timing:** `rx_ack` and `tx_ack` each rise 1 cycle after their request and fall 1 cycle after the request drops.
- **Back-to-back TX:** a new capture is possible on the edge after `tx_empty`=1, provided `tx_ack`=0.
- **Concurrency:** TX and RX are fully independent and may run simultaneously.

## Test plan
- **Reset:** `reset_n` low for 3 cycles in the middle of a TX frame and an RX frame → all outputs take their reset values. No `rx_frame_err` and no spurious character afterward.
- **Transmit 0x55:** `tx_req` high until `tx_ack` → `tx_ack`/`tx_empty` change 1 cycle later. `tx_out` sequence is 0,1,0,1,0,1,0,1,0,1, one `tx_clk` period per bit. `tx_empty`=1 at the end of the stop bit, not before.
- **Loopback 0x8D:** `tx_out` tied to `rx_in`, `tx_clk`=`rx_clk`/16 → `rx_empty` falls after the stop sample. `rx_req` then gives `rx_ack`=1, `rx_data`=0x8D and `rx_empty`=1 on the same edge. `rx_ack` drops 1 cycle after `rx_req` drops.
- **False start:** `rx_in` low for 5 `rx_clk` strobes, then high → no character, `rx_empty` stays 1, no flags.
- **Framing error:** send 0x41 with stop bit 0, then hold the line low for 2 bit times → a single `rx_frame_err` pulse and `rx_empty` stays 1. After the line returns high, 0x42 is received correctly.
- **Overrun, then overlap:**
  - Part 1: 0x31 then 0x32 with no `rx_req` → `rx_overrun`=1. A read returns 0x32 and clears `rx_overrun`.
  - Part 2: a character completes on the acceptance edge → the old value is returned, the new one is held, and `rx_overrun` stays 0.

Source files
------------

// File: rtl/pdp8_tt_uart_if.sv
// Console-controller side handshakes of the PDP-8 teletype serial engine.
// The controller drives requests (master); the UART answers (slave).
interface pdp8_tt_uart_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       tx_empty;
  logic       rx_req;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_overrun;
  logic       rx_frame_err;

  modport master (
    output tx_req, tx_data, rx_req,
    input  tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_overrun, rx_frame_err
  );

  modport slave (
    input  tx_req, tx_data, rx_req,
    output tx_ack, tx_empty, rx_ack, rx_data, rx_empty, rx_overrun, rx_frame_err
  );
endinterface

// File: rtl/pdp8_tt_uart.sv
// 8N1 transmitter and oversampling receiver for the PDP-8 console, with a
// one-character receive holding register and level req/ack handshakes.
module pdp8_tt_uart #(
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_clk,
  input  logic             rx_clk,
  input  logic             rx_in,
  output logic             tx_out,
  pdp8_tt_uart_if.slave    bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_WAIT_BIT = 3'd1, TX_START = 3'd2, TX_DATA = 3'd3, TX_STOP = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_BREAK = 3'd4
  } rx_state_t;

  tx_state_t     tx_state_r, tx_state_s;
  logic [7:0]    tx_sh_r, tx_sh_s;
  logic [2:0]    tx_cnt_r, tx_cnt_s;
  logic          tx_out_r, tx_out_s;
  logic          tx_ack_r, tx_ack_s;
  logic          tx_empty_r, tx_empty_s;

  logic          sync1_r, sync2_r;
  rx_state_t     rx_state_r, rx_state_s;
  logic [CW-1:0] rx_cnt_r, rx_cnt_s;
  logic [2:0]    rx_bit_r, rx_bit_s;
  logic [7:0]    rx_sh_r, rx_sh_s;
  logic [7:0]    hold_r, hold_s;
  logic [7:0]    rx_data_r, rx_data_s;
  logic          rx_ack_r, rx_ack_s;
  logic          rx_empty_r, rx_empty_s;
  logic          rx_ovr_r, rx_ovr_s;
  logic          rx_ferr_r;
  logic          done_s, ferr_s, accept_s;

  // TX next-state: capture, then start/8 data/stop bits paced by tx_clk
  always_comb begin
    tx_state_s = tx_state_r;
    tx_sh_s    = tx_sh_r;
    tx_cnt_s   = tx_cnt_r;
    tx_out_s   = tx_out_r;
    tx_empty_s = tx_empty_r;
    if (tx_ack_r && !bus.tx_req) tx_ack_s = 1'b0;
    else                         tx_ack_s = tx_ack_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (!tx_ack_r && bus.tx_req) begin
          tx_sh_s    = bus.tx_data;
          tx_ack_s   = 1'b1;
          tx_empty_s = 1'b0;
          tx_state_s = TX_WAIT_BIT;
        end else begin
          tx_out_s = 1'b1;
        end
      end
      TX_WAIT_BIT: begin
        if (tx_clk) begin
          tx_out_s   = 1'b0;
          tx_state_s = TX_START;
        end else begin
          tx_state_s = TX_WAIT_BIT;
        end
      end
      TX_START: begin
        if (tx_clk) begin
          tx_out_s   = tx_sh_r[0];
          tx_sh_s    = {1'b0, tx_sh_r[7:1]};
          tx_cnt_s   = 3'd0;
          tx_state_s = TX_DATA;
        end else begin
          tx_state_s = TX_START;
        end
      end
      TX_DATA: begin
        // bit0 went out on entry, so counts 0..6 drive bits 1..7
        if (tx_clk) begin
          if (tx_cnt_r == 3'd7) begin
            tx_out_s   = 1'b1;
            tx_state_s = TX_STOP;
          end else begin
            tx_out_s = tx_sh_r[0];
            tx_sh_s  = {1'b0, tx_sh_r[7:1]};
            tx_cnt_s = tx_cnt_r + 3'd1;
          end
        end else begin
          tx_state_s = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_clk) begin
          tx_empty_s = 1'b1;
          tx_state_s = TX_IDLE;
        end else begin
          tx_state_s = TX_STOP;
        end
      end
      default: begin
        tx_out_s   = 1'b1;
        tx_empty_s = 1'b1;
        tx_state_s = TX_IDLE;
      end
    endcase
  end

  // TX state and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_r <= TX_IDLE;
      tx_sh_r    <= 8'd0;
      tx_cnt_r   <= 3'd0;
      tx_out_r   <= 1'b1;
      tx_ack_r   <= 1'b0;
      tx_empty_r <= 1'b1;
    end else begin
      tx_state_r <= tx_state_s;
      tx_sh_r    <= tx_sh_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_out_r   <= tx_out_s;
      tx_ack_r   <= tx_ack_s;
      tx_empty_r <= tx_empty_s;
    end
  end

  // RX next-state: all sampling of the synchronized line happens on rx_clk
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_bit_s   = rx_bit_r;
    rx_sh_s    = rx_sh_r;
    done_s     = 1'b0;
    ferr_s     = 1'b0;
    if (rx_clk) begin
      case (rx_state_r)
        RX_IDLE: begin
          if (!sync2_r) begin
            rx_cnt_s   = {CW{1'b0}};
            rx_state_s = RX_START;
          end else begin
            rx_state_s = RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt_r == CNT_MID) begin
            if (sync2_r) begin
              rx_state_s = RX_IDLE;
            end else begin
              rx_cnt_s   = {CW{1'b0}};
              rx_bit_s   = 3'd0;
              rx_state_s = RX_DATA;
            end
          end else begin
            rx_cnt_s = rx_cnt_r + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == CNT_LAST) begin
            rx_sh_s  = {sync2_r, rx_sh_r[7:1]};
            rx_cnt_s = {CW{1'b0}};
            if (rx_bit_r == 3'd7) rx_state_s = RX_STOP;
            else                  rx_bit_s   = rx_bit_r + 3'd1;
          end else begin
            rx_cnt_s = rx_cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == CNT_LAST) begin
            rx_cnt_s = {CW{1'b0}};
            if (sync2_r) begin
              done_s     = 1'b1;
              rx_state_s = RX_IDLE;
            end else begin
              ferr_s     = 1'b1;
              rx_state_s = RX_BREAK;
            end
          end else begin
            rx_cnt_s = rx_cnt_r + CNT_ONE;
          end
        end
        RX_BREAK: begin
          if (sync2_r) rx_state_s = RX_IDLE;
          else         rx_state_s = RX_BREAK;
        end
        default: rx_state_s = RX_IDLE;
      endcase
    end else begin
      rx_state_s = rx_state_r;
    end
  end

  // Holding register, read handshake and overrun bookkeeping
  always_comb begin
    accept_s  = bus.rx_req && !rx_empty_r && !rx_ack_r;
    rx_data_s = rx_data_r;
    hold_s    = hold_r;
    if (accept_s) begin
      rx_data_s = hold_r;
      rx_ack_s  = 1'b1;
    end else if (rx_ack_r && !bus.rx_req) begin
      rx_ack_s = 1'b0;
    end else begin
      rx_ack_s = rx_ack_r;
    end
    // a completion on the acceptance edge refills the register, so it stays full
    if (done_s) begin
      hold_s     = rx_sh_r;
      rx_empty_s = 1'b0;
    end else if (accept_s) begin
      rx_empty_s = 1'b1;
    end else begin
      rx_empty_s = rx_empty_r;
    end
    if (done_s && !rx_empty_r && !accept_s) rx_ovr_s = 1'b1;
    else if (accept_s)                      rx_ovr_s = 1'b0;
    else                                    rx_ovr_s = rx_ovr_r;
  end

  // RX synchronizer, state and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= {CW{1'b0}};
      rx_bit_r   <= 3'd0;
      rx_sh_r    <= 8'd0;
      hold_r     <= 8'd0;
      rx_data_r  <= 8'd0;
      rx_ack_r   <= 1'b0;
      rx_empty_r <= 1'b1;
      rx_ovr_r   <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      sync1_r    <= rx_in;
      sync2_r    <= sync1_r;
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_bit_r   <= rx_bit_s;
      rx_sh_r    <= rx_sh_s;
      hold_r     <= hold_s;
      rx_data_r  <= rx_data_s;
      rx_ack_r   <= rx_ack_s;
      rx_empty_r <= rx_empty_s;
      rx_ovr_r   <= rx_ovr_s;
      rx_ferr_r  <= ferr_s;
    end
  end

  assign tx_out           = tx_out_r;
  assign bus.tx_ack       = tx_ack_r;
  assign bus.tx_empty     = tx_empty_r;
  assign bus.rx_ack       = rx_ack_r;
  assign bus.rx_data      = rx_data_r;
  assign bus.rx_empty     = rx_empty_r;
  assign bus.rx_overrun   = rx_ovr_r;
  assign bus.rx_frame_err = rx_ferr_r;

endmodule

// File: tb/tb_pdp8_tt_uart.sv
// Randomized bench for pdp8_tt_uart: a frame-level model (bit timelines in
// absolute strobe counts) is compared against the DUT on every cycle.
module tb_pdp8_tt_uart;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset_n, tx_clk, rx_clk, rx_drv, loop, tx_out;
  wire logic rx_in;
  assign rx_in = loop ? tx_out : rx_drv;

  pdp8_tt_uart_if bus();

  pdp8_tt_uart #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .reset_n(reset_n), .tx_clk(tx_clk), .rx_clk(rx_clk),
    .rx_in(rx_in), .tx_out(tx_out), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, tx_strobes = 0, ferr_seen = 0, gcnt = 0;
  bit chk_en = 1'b0;

  // model state
  logic       m_tx_ack, m_tx_empty, m_cap;
  int         m_ticks;
  logic [9:0] m_frame;
  logic       m_d1, m_d2, m_v, m_done, m_ferr, m_acc, m_pe;
  int         m_sn = 0, m_t0 = 0, m_mode = 0, m_off, m_idx;
  logic [7:0] m_bits, m_hold, m_rx_data;
  logic       m_rx_ack, m_rx_empty, m_ovr;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // baud enables: rx_clk every 4 clk, tx_clk every 16 rx strobes
  initial begin
    rx_clk = 1'b0; tx_clk = 1'b0;
    forever begin
      @(posedge clk); #2;
      gcnt++;
      rx_clk = (gcnt % 4 == 0);
      tx_clk = (gcnt % 64 == 0);
    end
  end

  // behavioural model, advanced at each rising edge
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_tx_ack = 1'b0; m_tx_empty = 1'b1; m_ticks = 0; m_frame = 10'h3ff;
      m_d1 = 1'b1; m_d2 = 1'b1; m_mode = 0; m_ferr = 1'b0; m_bits = 8'd0;
      m_hold = 8'd0; m_rx_data = 8'd0; m_rx_ack = 1'b0; m_rx_empty = 1'b1; m_ovr = 1'b0;
    end else begin
      m_cap = !m_tx_ack && m_tx_empty && bus.tx_req;
      if (m_cap) begin
        m_frame = {1'b1, bus.tx_data, 1'b0};
        m_ticks = 0;
        m_tx_empty = 1'b0;
      end else if (!m_tx_empty && tx_clk) begin
        m_ticks++;
        if (m_ticks == 11) m_tx_empty = 1'b1;
      end
      if (m_cap) m_tx_ack = 1'b1;
      else if (!bus.tx_req) m_tx_ack = 1'b0;

      m_v = m_d2; m_d2 = m_d1; m_d1 = rx_in;
      m_done = 1'b0; m_ferr = 1'b0;
      if (rx_clk) begin
        m_sn++;
        if (m_mode == 0) begin
          if (!m_v) begin m_mode = 1; m_t0 = m_sn; end
        end else if (m_mode == 1) begin
          m_off = m_sn - m_t0;
          if (m_off == OS/2 && m_v) m_mode = 0;
          else if (m_off > OS/2 && (m_off - OS/2) % OS == 0) begin
            m_idx = (m_off - OS/2) / OS;
            if (m_idx <= 8) m_bits[m_idx-1] = m_v;
            else if (m_v) begin m_done = 1'b1; m_mode = 0; end
            else begin m_ferr = 1'b1; m_mode = 2; end
          end
        end else begin
          if (m_v) m_mode = 0;
        end
      end
      m_pe  = m_rx_empty;
      m_acc = bus.rx_req && !m_pe && !m_rx_ack;
      if (m_acc) begin
        m_rx_data = m_hold; m_rx_ack = 1'b1; m_ovr = 1'b0;
      end else if (!bus.rx_req) m_rx_ack = 1'b0;
      if (m_done) begin
        if (!m_pe && !m_acc) m_ovr = 1'b1;
        m_hold = m_bits; m_rx_empty = 1'b0;
      end else if (m_acc) m_rx_empty = 1'b1;
    end
    if (tx_clk) tx_strobes++;
  end

  function automatic logic exp_tx_out();
    if (!m_tx_empty && m_ticks >= 1 && m_ticks <= 10) return m_frame[m_ticks-1];
    return 1'b1;
  endfunction

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tx_out", tx_out, exp_tx_out());
      chk("tx_ack", bus.tx_ack, m_tx_ack);
      chk("tx_empty", bus.tx_empty, m_tx_empty);
      chk("rx_ack", bus.rx_ack, m_rx_ack);
      chk("rx_data", bus.rx_data, m_rx_data);
      chk("rx_empty", bus.rx_empty, m_rx_empty);
      chk("rx_overrun", bus.rx_overrun, m_ovr);
      chk("rx_frame_err", bus.rx_frame_err, m_ferr);
      if (bus.rx_frame_err) ferr_seen++;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_tx_out", tx_out, 8'd1);
    chk("rst_tx_empty", bus.tx_empty, 8'd1);
    chk("rst_tx_ack", bus.tx_ack, 8'd0);
    chk("rst_rx_ack", bus.rx_ack, 8'd0);
    chk("rst_rx_empty", bus.rx_empty, 8'd1);
    chk("rst_rx_data", bus.rx_data, 8'd0);
    chk("rst_rx_overrun", bus.rx_overrun, 8'd0);
    chk("rst_rx_frame_err", bus.rx_frame_err, 8'd0);
  endtask

  task automatic wait_strobes(input int target);
    int n = 0;
    while (tx_strobes < target && n < 5000) begin @(negedge clk); n++; end
    chk("strobe_wait", 8'(tx_strobes >= target), 8'd1);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (!bus.tx_empty && n < 2000) begin @(negedge clk); n++; end
    chk("tx_idle_wait", bus.tx_empty, 8'd1);
  endtask

  task automatic wait_rx_full();
    int n = 0;
    while (bus.rx_empty && n < 3000) begin @(negedge clk); n++; end
    chk("rx_full_wait", !bus.rx_empty, 8'd1);
  endtask

  task automatic tx_send(input logic [7:0] d);
    int n = 0;
    bus.tx_data = d; bus.tx_req = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.tx_ack && n < 2000);
    chk("tx_ack_wait", bus.tx_ack, 8'd1);
    bus.tx_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic rx_read(output logic [7:0] d);
    int n = 0;
    bus.rx_req = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.rx_ack && n < 100);
    chk("rx_ack_wait", bus.rx_ack, 8'd1);
    d = bus.rx_data;
    bus.rx_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_serial(input logic [7:0] d, input logic stop_bit, input int extra_low);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (64) @(negedge clk);
    end
    if (extra_low > 0) begin
      rx_drv = 1'b0;
      repeat (extra_low * 64) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (128) @(negedge clk);
  endtask

  initial begin
    logic [7:0] got, a, b;
    int n0, f0, n;
    reset_n = 1'b0; bus.tx_req = 1'b0; bus.tx_data = 8'd0; bus.rx_req = 1'b0;
    rx_drv = 1'b1; loop = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // transmit 0x55: literal line sequence and capture timing
    n0 = tx_strobes + (tx_clk ? 1 : 0);
    bus.tx_data = 8'h55; bus.tx_req = 1'b1;
    @(negedge clk);
    chk("tx55_ack", bus.tx_ack, 8'd1);
    chk("tx55_empty", bus.tx_empty, 8'd0);
    bus.tx_req = 1'b0;
    @(negedge clk);
    chk("tx55_ack_drop", bus.tx_ack, 8'd0);
    for (int k = 0; k < 10; k++) begin
      wait_strobes(n0 + k + 1);
      chk("tx55_bit", tx_out, 8'(k % 2));
      chk("tx55_busy", bus.tx_empty, 8'd0);
    end
    wait_strobes(n0 + 11);
    chk("tx55_done", bus.tx_empty, 8'd1);

    // loopback 0x8D
    loop = 1'b1;
    tx_send(8'h8D);
    wait_rx_full();
    bus.rx_req = 1'b1;
    @(negedge clk);
    chk("lb_ack", bus.rx_ack, 8'd1);
    chk("lb_data", bus.rx_data, 8'h8D);
    chk("lb_empty", bus.rx_empty, 8'd1);
    bus.rx_req = 1'b0;
    @(negedge clk);
    chk("lb_ack_drop", bus.rx_ack, 8'd0);
    wait_tx_idle();

    // reset in the middle of a looped-back frame
    f0 = ferr_seen;
    tx_send(8'($urandom));
    repeat (300) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("rst_no_char", bus.rx_empty, 8'd1);
    chk("rst_no_ferr", 8'(ferr_seen - f0), 8'd0);

    // false start
    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("fs_empty", bus.rx_empty, 8'd1);
    chk("fs_no_ferr", 8'(ferr_seen - f0), 8'd0);

    // framing error then recovery
    f0 = ferr_seen;
    send_serial(8'h41, 1'b0, 2);
    chk("fe_pulses", 8'(ferr_seen - f0), 8'd1);
    chk("fe_empty", bus.rx_empty, 8'd1);
    send_serial(8'h42, 1'b1, 0);
    wait_rx_full();
    rx_read(got);
    chk("fe_recover", got, 8'h42);

    // overrun
    send_serial(8'h31, 1'b1, 0);
    send_serial(8'h32, 1'b1, 0);
    chk("ovr_set", bus.rx_overrun, 8'd1);
    rx_read(got);
    chk("ovr_data", got, 8'h32);
    chk("ovr_clear", bus.rx_overrun, 8'd0);

    // acceptance on the same edge as a completion
    a = 8'($urandom); b = 8'($urandom);
    send_serial(a, 1'b1, 0);
    fork
      send_serial(b, 1'b1, 0);
      begin
        n = 0;
        while (!(m_mode == 1 && m_sn == m_t0 + OS/2 + 9*OS - 1 && rx_clk) && n < 2000) begin
          @(negedge clk); n++;
        end
        chk("ovl_sync", 8'(n < 2000), 8'd1);
        bus.rx_req = 1'b1;
        @(negedge clk);
        chk("ovl_ack", bus.rx_ack, 8'd1);
        chk("ovl_old", bus.rx_data, a);
        chk("ovl_full", bus.rx_empty, 8'd0);
        chk("ovl_no_ovr", bus.rx_overrun, 8'd0);
        bus.rx_req = 1'b0;
        @(negedge clk);
      end
    join
    rx_read(got);
    chk("ovl_new", got, b);

    // TX and RX running concurrently
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      fork
        begin
          repeat ($urandom_range(0, 50)) @(negedge clk);
          tx_send(a);
          wait_tx_idle();
        end
        send_serial(b, 1'b1, 0);
      join
      rx_read(got);
      chk("conc_rx", got, b);
    end

    // random loopback characters
    loop = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      repeat ($urandom_range(0, 70)) @(negedge clk);
      tx_send(a);
      wait_rx_full();
      rx_read(got);
      chk("rand_lb", got, a);
      wait_tx_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
